// File: rtl/adsr_envelope_generator_if.sv
// adsr_envelope_generator_if
//   Bundles the voice-side signals of the ADSR envelope generator.
//   master : key scanner / divider / control side (drives strobe, gate, rates)
//   slave  : envelope generator (consumes strobe, gate, rates; drives envelope,
//            env_state, active)
interface adsr_envelope_generator_if #(
  parameter int ENV_W = 8
);
  logic             CLK_100Hz;
  logic             gate;
  logic [ENV_W-1:0] attack_rate;
  logic [ENV_W-1:0] decay_rate;
  logic [ENV_W-1:0] sustain_level;
  logic [ENV_W-1:0] release_rate;
  logic [ENV_W-1:0] envelope;
  logic [2:0]       env_state;
  logic             active;

  modport master (
    output CLK_100Hz, gate, attack_rate, decay_rate, sustain_level, release_rate,
    input  envelope, env_state, active
  );

  modport slave (
    input  CLK_100Hz, gate, attack_rate, decay_rate, sustain_level, release_rate,
    output envelope, env_state, active
  );
endinterface

// File: rtl/adsr_envelope_generator.sv
// adsr_envelope_generator
//   ADSR amplitude envelope for one synth voice. The 100 Hz divider output is
//   synchronised and edge-detected into a one-clock step strobe; the key gate
//   is synchronised and edge-detected into rise/fall events.
// Ports
//   CLK_50_MHz : system clock
//   reset_n    : asynchronous active-low reset
//   bus        : slave side of adsr_envelope_generator_if
//                (CLK_100Hz, gate, rates, sustain in; envelope, env_state, active out)
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | silent, level held at 0
// ATTACK   | level rises by attack_rate per step up to ENV_MAX
// DECAY    | level falls by decay_rate per step down to sustain
// SUSTAIN  | level follows sustain_level on every step
// RELEASE  | level falls by release_rate per step down to 0
module adsr_envelope_generator #(
  parameter int ENV_W   = 8,
  parameter int SYNC_FF = 2
) (
  input  logic                         CLK_50_MHz,
  input  logic                         reset_n,
  adsr_envelope_generator_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  logic [SYNC_FF-1:0] r_clk_sync;
  logic [SYNC_FF-1:0] r_gate_sync;
  logic [SYNC_FF-1:0] r_warm;
  logic               r_clk_d;
  logic               r_gate_d;
  logic               r_gate_armed;
  state_t             r_state;
  logic [ENV_W-1:0]   r_lvl;

  logic               w_clk_s;
  logic               w_gate_s;
  logic               w_step;
  logic               w_gate_rise;
  logic               w_gate_fall;
  logic [ENV_W:0]     w_att_sum;
  logic [ENV_W:0]     w_dec_diff;
  logic [ENV_W:0]     w_rel_diff;
  logic [ENV_W-1:0]   w_att_lvl;
  logic [ENV_W-1:0]   w_dec_sat;
  logic [ENV_W-1:0]   w_dec_lvl;
  logic [ENV_W-1:0]   w_rel_lvl;
  state_t             w_state_ev;
  state_t             w_state_nxt;
  logic [ENV_W-1:0]   w_lvl_nxt;

  assign w_clk_s  = r_clk_sync[SYNC_FF-1];
  assign w_gate_s = r_gate_sync[SYNC_FF-1];
  assign w_step   = w_clk_s & ~r_clk_d;

  // A rise only counts once the synchroniser has seen a genuine low after
  // reset, so a key held through reset does not retrigger the voice.
  assign w_gate_rise = w_gate_s & ~r_gate_d & r_gate_armed;
  assign w_gate_fall = ~w_gate_s & r_gate_d;

  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync   <= '0;
      r_gate_sync  <= '0;
      r_warm       <= '0;
      r_clk_d      <= 1'b0;
      r_gate_d     <= 1'b0;
      r_gate_armed <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[SYNC_FF-2:0], bus.CLK_100Hz};
      r_gate_sync  <= {r_gate_sync[SYNC_FF-2:0], bus.gate};
      r_warm       <= {r_warm[SYNC_FF-2:0], 1'b1};
      r_clk_d      <= w_clk_s;
      r_gate_d     <= w_gate_s;
      r_gate_armed <= r_gate_armed | (r_warm[SYNC_FF-1] & ~w_gate_s);
    end
  end

  // Saturating step arithmetic; the extra MSB catches carry/borrow.
  assign w_att_sum  = {1'b0, r_lvl} + {1'b0, bus.attack_rate};
  assign w_att_lvl  = ((bus.attack_rate == '0) || w_att_sum[ENV_W]) ? ENV_MAX
                                                                    : w_att_sum[ENV_W-1:0];
  assign w_dec_diff = {1'b0, r_lvl} - {1'b0, bus.decay_rate};
  assign w_dec_sat  = w_dec_diff[ENV_W] ? '0 : w_dec_diff[ENV_W-1:0];
  // Also covers a level already below a freshly raised sustain.
  assign w_dec_lvl  = ((bus.decay_rate == '0) || (w_dec_sat < bus.sustain_level))
                      ? bus.sustain_level : w_dec_sat;
  assign w_rel_diff = {1'b0, r_lvl} - {1'b0, bus.release_rate};
  assign w_rel_lvl  = ((bus.release_rate == '0) || w_rel_diff[ENV_W]) ? '0
                                                                      : w_rel_diff[ENV_W-1:0];

  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_lvl   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lvl   <= w_lvl_nxt;
    end
  end

  // Gate events resolve first; a step on the same clock then applies the
  // arithmetic of the resulting state.
  always_comb begin
    w_state_ev  = r_state;
    w_state_nxt = r_state;
    w_lvl_nxt   = r_lvl;

    if (w_gate_rise) begin
      w_state_ev = S_ATTACK;
    end else if (w_gate_fall && (r_state == S_ATTACK || r_state == S_DECAY ||
                                 r_state == S_SUSTAIN)) begin
      w_state_ev = S_RELEASE;
    end
    w_state_nxt = w_state_ev;

    if (w_step) begin
      case (w_state_ev)
        S_ATTACK: begin
          w_lvl_nxt = w_att_lvl;
          if (w_att_lvl == ENV_MAX) w_state_nxt = S_DECAY;
        end
        S_DECAY: begin
          w_lvl_nxt = w_dec_lvl;
          if (w_dec_lvl == bus.sustain_level) w_state_nxt = S_SUSTAIN;
        end
        S_SUSTAIN: w_lvl_nxt = bus.sustain_level;
        S_RELEASE: begin
          w_lvl_nxt = w_rel_lvl;
          if (w_rel_lvl == '0) w_state_nxt = S_IDLE;
        end
        default: w_lvl_nxt = '0;
      endcase
    end
  end

  assign bus.envelope  = r_lvl;
  assign bus.env_state = r_state;
  assign bus.active    = (r_state != S_IDLE);

endmodule
